// File: rtl/sram_1p_rmw_ctrl.sv
// -----------------------------------------------------------------------------
// sram_1p_rmw_ctrl
//
// This is the initiator-side controller for one single-port SG13G2 SRAM macro.
// The macro pins are MEN, WEN, REN, ADDR, DIN, DOUT and DLY.
//
// Requests are whole words with byte enables. Full-word reads and writes go
// straight to the macro. Partial writes become a read-modify-write, because
// the macro has no bit mask.
//
// Every accepted request gets exactly one response, in accept order.
//
// Request handshake (valid/ready):
//   - A request transfers in any cycle where req_valid_i && req_ready_o are
//     both high at the rising clk_i edge.
//   - req_ready_o depends only on controller state, never on req_valid_i.
//   - Response is a one-cycle rsp_valid_o pulse with no backpressure.
//   - rsp_rdata_o is zero for write responses.
//
// Ports:
//   clk_i, rst_ni        clock (also the macro clock), async active-low reset
//   req_valid_i/ready_o  request handshake
//   req_we_i             1 = write, 0 = read
//   req_addr_i           word address
//   req_wdata_i          write data
//   req_be_i             byte enables (writes only)
//   rsp_valid_o          response pulse
//   rsp_rdata_o          read data, zero for writes
//   sram_men_o           macro enable
//   sram_wen_o           macro write enable
//   sram_ren_o           macro read enable
//   sram_addr_o          macro address
//   sram_din_o           macro write data
//   sram_dly_o           macro DLY pin, tied to SRAM_DLY
//   sram_dout_i          macro read data, valid the cycle after a read edge
//
// Optional build macro SRAM_RDATA_REG_EN:
//   When defined, the response passes through one extra register stage.
//   This adds one cycle of latency to every response.
//
// FSM state is visible hierarchically as state_q (IDLE / MERGE).
// -----------------------------------------------------------------------------
module sram_1p_rmw_ctrl #(
  parameter int   ADDR_W   = 13,
  parameter int   DATA_W   = 32,
  parameter logic SRAM_DLY = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [DATA_W/8-1:0] req_be_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              sram_men_o,
  output logic              sram_wen_o,
  output logic              sram_ren_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [DATA_W-1:0] sram_din_o,
  output logic              sram_dly_o,
  input  logic [DATA_W-1:0] sram_dout_i
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] cap_addr_q;
  logic [DATA_W-1:0] cap_wdata_q;
  logic [BE_W-1:0]   cap_be_q;

  // A response is due in the cycle after rsp_pend_q is set.
  // rsp_read_q selects macro data versus zero for that response.
  logic              rsp_pend_q;
  logic              rsp_read_q;

  logic              accept;
  logic              be_full;
  logic              be_zero;
  logic              is_partial;
  logic [DATA_W-1:0] merge_data;

  // Ready is forced low during reset so nothing is accepted then.
  assign req_ready_o = rst_ni && (state_q == IDLE);
  assign accept      = req_valid_i && req_ready_o;
  assign be_full     = &req_be_i;
  assign be_zero     = ~|req_be_i;
  assign is_partial  = accept && req_we_i && !be_full && !be_zero;
  assign sram_dly_o  = SRAM_DLY;

  // Byte merge for the second half of a read-modify-write.
  // Enabled bytes come from the captured request. Other bytes come from the
  // word the macro read back in the previous cycle.
  always_comb begin
    merge_data = '0;
    for (int b = 0; b < BE_W; b++) begin
      merge_data[b*8 +: 8] = cap_be_q[b] ? cap_wdata_q[b*8 +: 8]
                                         : sram_dout_i[b*8 +: 8];
    end
  end

  // Macro pin drive.
  // All pins are quiet unless an access is actually being issued.
  // Gating MERGE with rst_ni drops the pending write when reset arrives
  // mid-sequence.
  always_comb begin
    sram_men_o  = 1'b0;
    sram_wen_o  = 1'b0;
    sram_ren_o  = 1'b0;
    sram_addr_o = '0;
    sram_din_o  = '0;
    if (rst_ni) begin
      if (state_q == MERGE) begin
        sram_men_o  = 1'b1;
        sram_wen_o  = 1'b1;
        sram_addr_o = cap_addr_q;
        sram_din_o  = merge_data;
      end else if (accept) begin
        if (!req_we_i) begin
          sram_men_o  = 1'b1;
          sram_ren_o  = 1'b1;
          sram_addr_o = req_addr_i;
        end else if (be_full) begin
          sram_men_o  = 1'b1;
          sram_wen_o  = 1'b1;
          sram_addr_o = req_addr_i;
          sram_din_o  = req_wdata_i;
        end else if (!be_zero) begin
          // Partial write: fetch the old word first.
          sram_men_o  = 1'b1;
          sram_ren_o  = 1'b1;
          sram_addr_o = req_addr_i;
        end
      end
    end
  end

  // FSM, request capture and response scheduling.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
      cap_be_q    <= '0;
      rsp_pend_q  <= 1'b0;
      rsp_read_q  <= 1'b0;
    end else begin
      case (state_q)
        MERGE: begin
          state_q    <= IDLE;
          rsp_pend_q <= 1'b1;
          rsp_read_q <= 1'b0;
        end
        default: begin
          if (is_partial) begin
            state_q     <= MERGE;
            cap_addr_q  <= req_addr_i;
            cap_wdata_q <= req_wdata_i;
            cap_be_q    <= req_be_i;
            rsp_pend_q  <= 1'b0;
            rsp_read_q  <= 1'b0;
          end else if (accept) begin
            rsp_pend_q <= 1'b1;
            rsp_read_q <= !req_we_i;
          end else begin
            rsp_pend_q <= 1'b0;
            rsp_read_q <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef SRAM_RDATA_REG_EN
  // Extra output stage: the response is registered one more time.
  // The merge path above still uses raw sram_dout_i.
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= rsp_pend_q;
      rsp_rdata_q <= rsp_read_q ? sram_dout_i : '0;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
`else
  // Read data is a combinational pass-through of the macro output.
  assign rsp_valid_o = rsp_pend_q;
  assign rsp_rdata_o = rsp_read_q ? sram_dout_i : '0;
`endif

endmodule

// File: tb/tb_sram_1p_rmw_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for sram_1p_rmw_ctrl.
//
// It includes a behavioural single-port macro model. Directed requests push
// their hand-computed response data and the cycle the response is due into
// queues. A negedge monitor pops and compares on every rsp_valid_o.
// -----------------------------------------------------------------------------
module tb_sram_1p_rmw_ctrl;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

`ifdef SRAM_RDATA_REG_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              sram_men;
  logic              sram_wen;
  logic              sram_ren;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_din;
  logic              sram_dly;
  logic [DATA_W-1:0] sram_dout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int men_cnt = 0;
  int wen_cnt = 0;

  logic [DATA_W-1:0] exp_q[$];
  int                exp_cyc_q[$];

  sram_1p_rmw_ctrl #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .SRAM_DLY(1'b1)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_we_i   (req_we),
    .req_addr_i (req_addr),
    .req_wdata_i(req_wdata),
    .req_be_i   (req_be),
    .rsp_valid_o(rsp_valid),
    .rsp_rdata_o(rsp_rdata),
    .sram_men_o (sram_men),
    .sram_wen_o (sram_wen),
    .sram_ren_o (sram_ren),
    .sram_addr_o(sram_addr),
    .sram_din_o (sram_din),
    .sram_dly_o (sram_dly),
    .sram_dout_i(sram_dout)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- macro model ----------------
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    sram_dout = '0;
  end

  always @(posedge clk) begin
    if (sram_men) begin
      men_cnt++;
      if (sram_wen) begin
        mem[sram_addr] <= sram_din;
        wen_cnt++;
      end
      if (sram_ren) sram_dout <= mem[sram_addr];
    end
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [DATA_W-1:0] d;
    int                c;
    if (sram_wen && sram_ren) begin
      checks++;
      errors++;
      $display("FAIL wen_ren_both at cycle %0d", cyc);
    end
    if (rsp_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp at cycle %0d rdata %h", cyc, rsp_rdata);
      end else begin
        d = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        if (rsp_rdata !== d || cyc != c) begin
          errors++;
          $display("FAIL rsp: got data %h at cycle %0d, expected %h at cycle %0d",
                   rsp_rdata, cyc, d, c);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge. It returns at the negedge after the accept edge.
  // A negative lat means no response is expected.
  task automatic issue(input logic we, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wdata, input logic [BE_W-1:0] be,
                       input logic [DATA_W-1:0] exp, input int lat);
    int n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout addr %h: ready %b expected 1", addr, req_ready);
      req_valid = 1'b0;
      return;
    end
    if (lat >= 0) begin
      exp_q.push_back(exp);
      exp_cyc_q.push_back(cyc + lat + EXTRA);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
  endtask

  // ---------------- stimulus ----------------
  int snap;

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 13'h0005;
    req_wdata = '0;
    req_be    = '0;

    // Reset state, with a request already presented.
    @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'h0);
    check("rst_men",   {31'b0, sram_men},  32'h0);
    check("rst_wen",   {31'b0, sram_wen},  32'h0);
    check("rst_ren",   {31'b0, sram_ren},  32'h0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("dly", {31'b0, sram_dly}, 32'h1);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", {31'b0, req_ready}, 32'h1);

    // Full write, then read back.
    issue(1'b1, 13'h0005, 32'hDEADBEEF, 4'hF, 32'h0, 1);
    issue(1'b0, 13'h0005, 32'h0, 4'h0, 32'hDEADBEEF, 1);

    // Partial write as a read-modify-write.
    issue(1'b1, 13'h0010, 32'h11223344, 4'hF, 32'h0, 1);
    issue(1'b1, 13'h0010, 32'hAABBCCDD, 4'b0101, 32'h0, 2);
    check("merge_ready_low", {31'b0, req_ready}, 32'h0);
    issue(1'b0, 13'h0010, 32'h0, 4'h0, 32'h11BB33DD, 1);

    // Back-to-back reads of addresses 0..3.
    issue(1'b1, 13'h0000, 32'hA0A0A0A0, 4'hF, 32'h0, 1);
    issue(1'b1, 13'h0001, 32'hB1B1B1B1, 4'hF, 32'h0, 1);
    issue(1'b1, 13'h0002, 32'hC2C2C2C2, 4'hF, 32'h0, 1);
    issue(1'b1, 13'h0003, 32'hD3D3D3D3, 4'hF, 32'h0, 1);
    snap = men_cnt;
    issue(1'b0, 13'h0000, 32'h0, 4'h0, 32'hA0A0A0A0, 1);
    issue(1'b0, 13'h0001, 32'h0, 4'h0, 32'hB1B1B1B1, 1);
    issue(1'b0, 13'h0002, 32'h0, 4'h0, 32'hC2C2C2C2, 1);
    issue(1'b0, 13'h0003, 32'h0, 4'h0, 32'hD3D3D3D3, 1);
    idle();
    check("men_cycles_4_reads", men_cnt - snap, 32'd4);

    // Zero-byte write: no macro access, ack only.
    snap = men_cnt;
    issue(1'b1, 13'h0010, 32'hFFFFFFFF, 4'h0, 32'h0, 1);
    check("zero_write_no_men", men_cnt - snap, 32'd0);
    issue(1'b0, 13'h0010, 32'h0, 4'h0, 32'h11BB33DD, 1);

    // Partial write of the top byte only.
    issue(1'b1, 13'h0005, 32'h12345678, 4'b1000, 32'h0, 2);
    issue(1'b0, 13'h0005, 32'h0, 4'h0, 32'h12ADBEEF, 1);
    idle();

    // Reset during MERGE drops the write with no ack.
    issue(1'b1, 13'h0020, 32'h0, 4'hF, 32'h0, 1);
    idle();
    repeat (4) @(negedge clk);
    snap = wen_cnt;
    issue(1'b1, 13'h0020, 32'h000000FF, 4'b0001, 32'h0, -1);
    idle();
    rst_n = 1'b0;
    #1;
    check("rst_merge_wen", {31'b0, sram_wen}, 32'h0);
    check("rst_merge_men", {31'b0, sram_men}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_merge_no_wen_pulse", wen_cnt - snap, 32'd0);
    issue(1'b0, 13'h0020, 32'h0, 4'h0, 32'h00000000, 1);

    // Read right after a partial write.
    issue(1'b1, 13'h0003, 32'h00EE0000, 4'b0100, 32'h0, 2);
    issue(1'b0, 13'h0003, 32'h0, 4'h0, 32'hD3EED3D3, 1);
    idle();

    // Drain the scoreboard, with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses missing, expected 0", exp_q.size());
    end
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_1p_rmw_ctrl.md
Name: sram_1p_rmw_ctrl

Overview:
- Initiator-side controller for the single-port SG13G2 SRAM macros (MEN/WEN/REN/ADDR/DIN/DOUT/DLY pin set).
- Accepts word requests with byte enables on a valid/ready port and drives the macro pins.
- Converts partial-byte writes into a read-modify-write sequence, because the macro has no bit mask.
- Returns exactly one in-order response per accepted request.
- Sits between the SoC bus adapter and one macro instance; the macro is clocked by clk_i.

Parameters:
- ADDR_W, 13: word address width; macro depth is 2**ADDR_W.
- DATA_W, 32: word width; must be a multiple of 8.
- SRAM_DLY, 1'b1: constant driven on sram_dly_o.

Ports:
- clk_i  in  1  clock; also the macro clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- req_we_i  in  1  1 = write, 0 = read.
- req_addr_i  in  ADDR_W  word address.
- req_wdata_i  in  DATA_W  write data.
- req_be_i  in  DATA_W/8  byte enables; writes only.
- rsp_valid_o  out  1  one-cycle response pulse; no backpressure.
- rsp_rdata_o  out  DATA_W  read data; zero for write responses.
- sram_men_o  out  1  macro enable (A_MEN).
- sram_wen_o  out  1  macro write enable (A_WEN).
- sram_ren_o  out  1  macro read enable (A_REN).
- sram_addr_o  out  ADDR_W  macro address (A_ADDR).
- sram_din_o  out  DATA_W  macro write data (A_DIN).
- sram_dly_o  out  1  tied to SRAM_DLY.
- sram_dout_i  in  DATA_W  macro read data (A_DOUT), valid the cycle after a read edge.

Behaviour:
- FSM states: IDLE and MERGE. Reset state is IDLE.
- Reset values: rsp_valid_o=0, rsp_rdata_o=0, capture registers (addr, wdata, be) =0.
- While rst_ni=0: req_ready_o=0 and all sram_* enables =0.
- req_ready_o = (state==IDLE).
- A request is accepted when req_valid_i && req_ready_o in cycle T.
- Macro pins are driven combinationally during accept cycle T; the macro samples them at the end-of-T posedge.
- Read accept: men=1, ren=1, wen=0, addr=req_addr_i. Response at T+1 with rsp_rdata_o=sram_dout_i.
- Full write (be all ones): men=1, wen=1, ren=0, din=req_wdata_i. Ack at T+1 with rdata=0.
- Zero write (be all zeros): no macro access (men=0). Ack at T+1.
- Partial write, accept cycle T:
  - Issue a read at req_addr_i.
  - Capture addr, wdata and be.
  - Go to MERGE.
- Partial write, MERGE cycle T+1:
  - req_ready_o=0.
  - Drive men=1, wen=1, addr=captured addr.
  - Drive din, per byte: be ? wdata byte : sram_dout_i byte.
  - Return to IDLE. Ack at T+2.
- Throughput: one read or full write per cycle back-to-back. A partial write costs 2 cycles.
- Reads never see stale data: a read accepted at T+2 after a partial write returns the merged word.
- When no access is issued, sram_addr_o=0, sram_din_o=0, and wen=ren=0.
- sram_wen_o and sram_ren_o are never both 1.
- Responses are strictly in accept order. Write responses always carry rdata=0.
- Reset asserted mid-MERGE: the write is dropped with no macro access and no response. The word keeps its old value.

Optional Feature:
- SRAM_RDATA_REG_EN defined: rsp_valid_o and rsp_rdata_o pass through one extra register stage (reset 0).
  - Every response latency increases by 1 (read T+2, full/zero write T+2, partial write T+3).
  - The MERGE path still uses raw sram_dout_i.
- Undefined: the latencies listed in Behaviour apply, and rsp_rdata_o is a combinational pass-through of sram_dout_i.

Test Plan:
- Reset, then a full write of 0xDEADBEEF to addr 0x0005, then a read of 0x0005 -> ack at T+1, then read rsp rdata=0xDEADBEEF one cycle after its accept.
- Word 0x0010=0x11223344, then a write of 0xAABBCCDD with be=4'b0101 -> req_ready_o low for one cycle, ack at T+2, then a read of 0x0010 returns 0x11BB33DD.
- Back-to-back reads of addr 0,1,2,3 on consecutive cycles -> four consecutive rsp_valid_o pulses with matching data; sram_men_o high for 4 cycles.
- Write with be=4'b0000 -> sram_men_o stays 0, ack at T+1, and the word is unchanged on readback.
- Assert rst_ni during MERGE of a be=4'b0001 write to a word holding 0x00000000 -> no ack, no wen pulse, and a readback after reset returns 0x00000000.
- With SRAM_RDATA_REG_EN defined, read-after-partial-write sequence -> every response one cycle later than without the macro, data and order unchanged.
